// File: rtl/mem_handshake_ram.sv
// rtl/mem_handshake_ram.sv - byte-addressable big-endian RAM behind a MOV/MOC handshake
//
// One transaction at a time. Request fields are captured on the IDLE edge
// where mov=1. WAIT_CYCLES wait cycles follow, and then the array is accessed.
// moc stays high in DONE until mov is seen low.
//
// Ports
//   clk        clock, rising edge
//   clr        synchronous active-low reset
//   mov        memory operation valid (held until moc)
//   rw         1 = read, 0 = write
//   sign       1 = sign-extend read data, 0 = zero-extend
//   data_type  00 byte, 01 halfword, 1x word
//   addr       byte address; only addr[ADDR_BITS-1:0] is decoded
//   data_in    write data (byte [7:0], halfword [15:0], word [31:0])
//   data_out   registered, extended read data
//   moc        memory operation complete
//   err        misaligned access flag, valid while moc=1

module mem_handshake_ram #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mov,
  input  logic        rw,
  input  logic        sign,
  input  logic [1:0]  data_type,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]           cnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic                 rw_q;
  logic                 sign_q;
  logic [1:0]           dtype_q;

  logic [7:0] mem [0:DEPTH-1];

  logic                 access;
  logic                 misaligned;
  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic [31:0]          rd_ext;

  // Upper address bits are deliberately not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_BITS];

  // Byte lanes wrap modulo the array size.
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_BITS'(1);
  assign a2 = addr_q + ADDR_BITS'(2);
  assign a3 = addr_q + ADDR_BITS'(3);

  always_comb begin
    misaligned = 1'b0;
    if (dtype_q[1]) begin
      misaligned = (addr_q[1:0] != 2'b00);
    end else if (dtype_q[0]) begin
      misaligned = addr_q[0];
    end
  end

  // Big-endian assembly: lowest address is the most significant byte.
  always_comb begin
    rd_ext = 32'd0;
    case (dtype_q)
      2'b00: rd_ext = sign_q ? {{24{mem[a0][7]}}, mem[a0]}
                             : {24'd0, mem[a0]};
      2'b01: rd_ext = sign_q ? {{16{mem[a0][7]}}, mem[a0], mem[a1]}
                             : {16'd0, mem[a0], mem[a1]};
      default: rd_ext = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      IDLE: if (mov) state_d = WAIT;
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          access  = 1'b1;
        end
      end
      DONE: if (!mov) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      moc      <= 1'b0;
      err      <= 1'b0;
      data_out <= 32'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rw_q     <= 1'b0;
      sign_q   <= 1'b0;
      dtype_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (mov) begin
            addr_q  <= addr[ADDR_BITS-1:0];
            wdata_q <= data_in;
            rw_q    <= rw;
            sign_q  <= sign;
            dtype_q <= data_type;
            cnt_q   <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            moc <= 1'b1;
            if (misaligned) begin
              err <= 1'b1;
            end else if (rw_q) begin
              data_out <= rd_ext;
            end
          end
        end
        DONE: begin
          if (!mov) begin
            moc <= 1'b0;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (clr && access && !rw_q && !misaligned) begin
      case (dtype_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        default: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_ram.sv
// tb/tb_mem_handshake_ram.sv - table-driven self-checking bench for mem_handshake_ram

module tb_mem_handshake_ram;

  localparam int ADDR_BITS   = 9;
  localparam int WAIT_CYCLES = 2;
  localparam int LAT         = WAIT_CYCLES + 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        mov;
  logic        rw;
  logic        sign;
  logic [1:0]  data_type;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_handshake_ram #(
    .ADDR_BITS  (ADDR_BITS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .mov      (mov),
    .rw       (rw),
    .sign     (sign),
    .data_type(data_type),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .moc      (moc),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic        sign;
    logic [1:0]  dt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive a request and wait for moc; lat = rising edges from capture to moc.
  task automatic issue(input logic r, input logic s, input logic [1:0] d,
                       input logic [31:0] a, input logic [31:0] w, output int lat);
    int n;
    @(negedge clk);
    mov = 1'b1; rw = r; sign = s; data_type = d; addr = a; data_in = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!moc && n < 20);
    if (!moc) begin
      checks++;
      errors++;
      $display("FAIL moc_timeout: got moc=0 after %0d cycles expected moc=1", n);
    end
    lat = n - 1;
  endtask

  task automatic finish_txn(input string nm);
    mov = 1'b0;
    @(negedge clk);
    check({nm, "_moc_clear"}, {31'd0, moc}, 32'd0);
    check({nm, "_err_clear"}, {31'd0, err}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.rw, v.sign, v.dt, v.addr, v.wdata, lat);
    check({v.name, "_latency"}, 32'(lat), 32'(LAT));
    check({v.name, "_data"}, data_out, v.exp_data);
    check({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    finish_txn(v.name);
  endtask

  initial begin
    int lat;
    int n;

    vecs[0]  = '{"w_word_010",    1'b0, 1'b0, 2'b10, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{"r_word_010",    1'b1, 1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"r_byte_011_s",  1'b1, 1'b1, 2'b00, 32'h011, 32'h0,        32'hFFFFFFAD, 1'b0};
    vecs[3]  = '{"r_byte_011_z",  1'b1, 1'b0, 2'b00, 32'h011, 32'h0,        32'h000000AD, 1'b0};
    vecs[4]  = '{"r_half_012_s",  1'b1, 1'b1, 2'b01, 32'h012, 32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{"r_half_010_z",  1'b1, 1'b0, 2'b01, 32'h010, 32'h0,        32'h0000DEAD, 1'b0};
    vecs[6]  = '{"w_byte_013",    1'b0, 1'b0, 2'b00, 32'h013, 32'hFFFFFF55, 32'h0000DEAD, 1'b0};
    vecs[7]  = '{"r_word_merge",  1'b1, 1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADBE55, 1'b0};
    vecs[8]  = '{"r_word_mis",    1'b1, 1'b0, 2'b10, 32'h012, 32'h0,        32'hDEADBE55, 1'b1};
    vecs[9]  = '{"w_half_mis",    1'b0, 1'b0, 2'b01, 32'h011, 32'h00001234, 32'hDEADBE55, 1'b1};
    vecs[10] = '{"r_word_after",  1'b1, 1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADBE55, 1'b0};
    vecs[11] = '{"w_word_alias",  1'b0, 1'b0, 2'b10, 32'h214, 32'h01020304, 32'hDEADBE55, 1'b0};
    vecs[12] = '{"r_word_014",    1'b1, 1'b0, 2'b10, 32'h014, 32'h0,        32'h01020304, 1'b0};
    vecs[13] = '{"r_half_016",    1'b1, 1'b1, 2'b01, 32'h016, 32'h0,        32'h00000304, 1'b0};
    vecs[14] = '{"r_byte_217",    1'b1, 1'b1, 2'b00, 32'h217, 32'h0,        32'h00000004, 1'b0};
    vecs[15] = '{"r_word_210",    1'b1, 1'b0, 2'b10, 32'h210, 32'h0,        32'hDEADBE55, 1'b0};
    vecs[16] = '{"w_half_1fe",    1'b0, 1'b0, 2'b01, 32'h1FE, 32'h00008081, 32'hDEADBE55, 1'b0};
    vecs[17] = '{"r_half_1fe",    1'b1, 1'b1, 2'b01, 32'h1FE, 32'h0,        32'hFFFF8081, 1'b0};
    vecs[18] = '{"r_dt3_014",     1'b1, 1'b0, 2'b11, 32'h014, 32'h0,        32'h01020304, 1'b0};
    vecs[19] = '{"r_byte_1fe",    1'b1, 1'b1, 2'b00, 32'h1FE, 32'h0,        32'hFFFFFF80, 1'b0};

    clr = 1'b0; mov = 1'b0; rw = 1'b0; sign = 1'b0;
    data_type = 2'b00; addr = 32'd0; data_in = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_moc", {31'd0, moc}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_data", data_out, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i]);
    end

    // mov drops right after capture: moc pulses one cycle, write still lands
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; sign = 1'b0; data_type = 2'b10;
    addr = 32'h020; data_in = 32'hCAFEF00D;
    @(negedge clk);
    mov = 1'b0;
    n = 1;
    while (!moc && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drop_latency", 32'(n - 1), 32'(LAT));
    @(negedge clk);
    check("drop_moc_pulse", {31'd0, moc}, 32'd0);
    run_vec('{"r_word_020", 1'b1, 1'b0, 2'b10, 32'h020, 32'h0, 32'hCAFEF00D, 1'b0});

    // mov held 5 extra cycles in DONE
    issue(1'b1, 1'b0, 2'b10, 32'h014, 32'h0, lat);
    check("hold_latency", 32'(lat), 32'(LAT));
    check("hold_data", data_out, 32'h01020304);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_moc", {31'd0, moc}, 32'd1);
    end
    finish_txn("hold");

    // reset on the edge the write would occur
    run_vec('{"w_word_030", 1'b0, 1'b0, 2'b10, 32'h030, 32'h11111111, 32'h01020304, 1'b0});
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; data_type = 2'b10; addr = 32'h030; data_in = 32'h22222222;
    repeat (3) @(negedge clk);
    check("rst_pre_moc", {31'd0, moc}, 32'd0);
    clr = 1'b0;
    mov = 1'b0;
    @(negedge clk);
    check("rst_moc", {31'd0, moc}, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    clr = 1'b1;
    @(negedge clk);
    check("rst_idle_moc", {31'd0, moc}, 32'd0);
    run_vec('{"r_word_030", 1'b1, 1'b0, 2'b10, 32'h030, 32'h0, 32'h11111111, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
